skid_pipe_stage: RTL and testbench

Two-entry skid buffer that forms one registered stage of a valid/ready datapath pipeline. Both the forward path (valid/data) and the backward path (ready) are fully registered, so stages can be chained without combinational paths. Every payload register is an enable flop, and each enable is a known-value function of the handshake signals. The block sits directly upstream of the enable-flop storage it drives and produces those enables.

---
 rtl/skid_pipe_stage.sv | 102 ++++++++++
 tb/tb_skid_pipe_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/skid_pipe_stage.sv
// Two-entry skid buffer forming one fully registered valid/ready pipeline stage.
// Payload lives in two enable flops (main drives out_data, skid absorbs the stall beat).
module skid_pipe_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    input  logic         out_rdy,
    output logic [1:0]   occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         inRdy_q;
    logic [W-1:0] mainData_q;
    logic [W-1:0] skidData_q;
    logic         accept;
    logic         pop;
    logic         mainEn;
    logic         skidEn;

    assign out_vld  = (state_q != EMPTY);
    assign in_rdy   = inRdy_q;
    assign occ      = state_q;
    assign out_data = mainData_q;
    assign accept   = in_vld & inRdy_q;
    assign pop      = out_vld & out_rdy;

    // Next state and storage enables; flush overrides everything and drops any accepted beat.
    always_comb begin
        state_d = state_q;
        mainEn  = 1'b0;
        skidEn  = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        mainEn  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        mainEn = 1'b1;
                    end else if (accept) begin
                        state_d = FULL;
                        skidEn  = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        mainEn  = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_rdy is held low through reset and rises on the first edge afterwards.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= EMPTY;
            inRdy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inRdy_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (mainEn) begin
            mainData_q <= (state_q == FULL) ? skidData_q : in_data;
        end
        if (skidEn) begin
            skidData_q <= in_data;
        end
    end

    ctrlKnown: assert property (@(posedge clk) disable iff (!arst_n)
        !$isunknown({in_vld, out_rdy, flush}));

    enableKnown: assert property (@(posedge clk) disable iff (!arst_n)
        !$isunknown({mainEn, skidEn}));

endmodule

// File: tb/tb_skid_pipe_stage.sv
// Self-checking bench for skid_pipe_stage: directed vector table, hand-written
// reset sequences, and a randomised FIFO-order check against a queue model.
module tb_skid_pipe_stage;

    localparam int W = 32;

    logic         clk;
    logic         arst_n;
    logic         flush;
    logic         in_vld;
    logic [W-1:0] in_data;
    logic         in_rdy;
    logic         out_vld;
    logic [W-1:0] out_data;
    logic         out_rdy;
    logic [1:0]   occ;

    int checks;
    int errors;

    typedef struct {
        logic        inVld;
        logic [31:0] inData;
        logic        outRdy;
        logic        flush;
        logic [1:0]  expOcc;
        logic        expVld;
        logic        expRdy;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    skid_pipe_stage #(.W(W)) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .occ      (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkState(input string tag, input logic [1:0] eOcc, input logic eVld, input logic eRdy);
        checkOutput({tag, ".occ"}, {30'd0, occ}, {30'd0, eOcc});
        checkOutput({tag, ".out_vld"}, {31'd0, out_vld}, {31'd0, eVld});
        checkOutput({tag, ".in_rdy"}, {31'd0, in_rdy}, {31'd0, eRdy});
    endtask

    // Drive inputs for one cycle, then land 1 time unit after the rising edge.
    task automatic applyStimulus(input logic vld, input logic [31:0] data, input logic rdy, input logic fl);
        in_vld  = vld;
        in_data = data;
        out_rdy = rdy;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic vld, input logic [31:0] data, input logic rdy, input logic fl,
                          input logic [1:0] eOcc, input logic eVld, input logic eRdy, input logic [31:0] eData);
        vec_t v;
        v.inVld = vld; v.inData = data; v.outRdy = rdy; v.flush = fl;
        v.expOcc = eOcc; v.expVld = eVld; v.expRdy = eRdy; v.expData = eData;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] model[$];
        logic        rVld;
        logic        rRdy;
        logic [31:0] rData;
        logic        acc;
        logic        pp;

        checks  = 0;
        errors  = 0;
        arst_n  = 1'b0;
        flush   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;

        // Streaming at full rate, one cycle latency.
        for (int i = 1; i <= 8; i++) addVec(1, i, 1, 0, 2'd1, 1, 1, i);
        addVec(0, 0, 1, 0, 2'd0, 0, 1, 0);
        // Stall fills exactly two beats, 0xC waits upstream, then drains without bubbles.
        addVec(1, 32'hA, 0, 0, 2'd1, 1, 1, 32'hA);
        addVec(1, 32'hB, 0, 0, 2'd2, 1, 0, 32'hA);
        addVec(1, 32'hC, 0, 0, 2'd2, 1, 0, 32'hA);
        addVec(1, 32'hC, 1, 0, 2'd1, 1, 1, 32'hB);
        addVec(1, 32'hC, 1, 0, 2'd1, 1, 1, 32'hC);
        addVec(0, 0, 1, 0, 2'd0, 0, 1, 0);
        // Simultaneous accept and pop in ONE.
        addVec(1, 32'h5, 0, 0, 2'd1, 1, 1, 32'h5);
        addVec(1, 32'h6, 1, 0, 2'd1, 1, 1, 32'h6);
        addVec(0, 0, 0, 0, 2'd1, 1, 1, 32'h6);
        // Fill to FULL, then flush with a beat offered.
        addVec(1, 32'h7, 0, 0, 2'd2, 1, 0, 32'h6);
        addVec(1, 32'h9, 0, 1, 2'd0, 0, 1, 0);
        addVec(0, 0, 1, 0, 2'd0, 0, 1, 0);
        // Flush in ONE with an accept and pop: accepted beat is dropped.
        addVec(1, 32'h11, 0, 0, 2'd1, 1, 1, 32'h11);
        addVec(1, 32'h12, 1, 1, 2'd0, 0, 1, 0);
        addVec(0, 0, 0, 0, 2'd0, 0, 1, 0);
        // Skid ordering after a refill.
        addVec(1, 32'h31, 0, 0, 2'd1, 1, 1, 32'h31);
        addVec(1, 32'h32, 0, 0, 2'd2, 1, 0, 32'h31);
        addVec(0, 0, 1, 0, 2'd1, 1, 1, 32'h32);
        addVec(0, 0, 1, 0, 2'd0, 0, 1, 0);

        // Reset held for 3 cycles, released mid-cycle.
        repeat (3) @(posedge clk);
        #1;
        checkState("reset", 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        checkOutput("rdyBeforeEdge", {31'd0, in_rdy}, 32'd0);
        @(posedge clk);
        #1;
        checkState("afterRelease", 2'd0, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].inVld, vecs[i].inData, vecs[i].outRdy, vecs[i].flush);
            checkState($sformatf("vec%0d", i), vecs[i].expOcc, vecs[i].expVld, vecs[i].expRdy);
            if (vecs[i].expVld) checkOutput($sformatf("vec%0d.data", i), out_data, vecs[i].expData);
        end

        // Randomised traffic against a queue model (no flush).
        for (int c = 0; c < 300; c++) begin
            rVld  = 1'($urandom_range(0, 1));
            rRdy  = ($urandom_range(0, 3) != 0);
            rData = $urandom;
            acc   = rVld && (model.size() < 2);
            pp    = rRdy && (model.size() > 0);
            applyStimulus(rVld, rData, rRdy, 1'b0);
            if (pp) void'(model.pop_front());
            if (acc) model.push_back(rData);
            checkOutput("rnd.occ", {30'd0, occ}, model.size());
            checkOutput("rnd.in_rdy", {31'd0, in_rdy}, {31'd0, model.size() < 2});
            if (model.size() > 0) checkOutput("rnd.data", out_data, model[0]);
        end

        // Async reset while FULL: outputs drop immediately, mid-cycle.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 32'h21, 0, 0);
        applyStimulus(1, 32'h22, 0, 0);
        checkState("preReset", 2'd2, 1'b1, 1'b0);
        in_vld = 1'b0;
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        checkState("asyncReset", 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkState("resetHeld", 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        checkState("reRelease", 2'd0, 1'b0, 1'b1);
        applyStimulus(1, 32'h44, 0, 0);
        checkState("postReset", 2'd1, 1'b1, 1'b1);
        checkOutput("postReset.data", out_data, 32'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
